// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-byte prefetcher.
// The FSM walks IDLE -> FETCH and passes through REDIRECT after every flush.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/fetch_queue_if.sv
// Prefetcher handshake bundle: the control inputs, the ROM read port and the byte stream to decode.
// master = prefetcher side, slave = environment side (ROM, decoder, sequencer).
interface fetch_queue_if #(
    parameter int ADDR_W = 16
);
    logic              fetch_en;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_byte;
    logic [7:0]        byte_out;
    logic [ADDR_W-1:0] byte_pc;
    logic              byte_vld;
    logic              byte_rdy;

    modport master (
        input  fetch_en, flush, flush_addr, rom_byte, byte_rdy,
        output rom_en, rom_addr, byte_out, byte_pc, byte_vld
    );

    modport slave (
        output fetch_en, flush, flush_addr, rom_byte, byte_rdy,
        input  rom_en, rom_addr, byte_out, byte_pc, byte_vld
    );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH x 8 byte queue with head/tail pointers, occupancy count and a synchronous clear.
// Holds data only; the address of each byte is reconstructed by the parent.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [7:0]       i_data,
    output logic [7:0]       o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // NOTE: the storage is reset on purpose so the head byte reads 0 out of reset; fine at this tiny depth, not for large RAMs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (w_push && !i_clear) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
endmodule

// File: rtl/fetch_queue.sv
// Instruction-byte prefetcher: sequential ROM reads into a small queue, drained by a valid/ready consumer.
// A flush empties the queue, reloads the fetch address and inserts one REDIRECT bubble.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic           clock,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              w_rom_en;
    logic              w_push;
    logic              w_pop;
    logic              w_byte_vld;
    logic [7:0]        w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first means no path leaves the target unassigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = REDIRECT;
        end else begin
            case (r_state)
                IDLE:     w_next_state = bus.fetch_en ? FETCH : IDLE;
                FETCH:    w_next_state = bus.fetch_en ? FETCH : IDLE;
                REDIRECT: w_next_state = bus.fetch_en ? FETCH : IDLE;
                default:  w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rom_en = 1'b0;
        if (r_state == FETCH) w_rom_en = !w_full;
    end

    // A read issued in the flush cycle still advances nothing: flush_addr wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_fetch_addr <= '0;
        else if (bus.flush) r_fetch_addr <= bus.flush_addr;
        else if (w_rom_en)  r_fetch_addr <= r_fetch_addr + 1'b1;
    end

    assign w_push     = w_rom_en && !bus.flush;
    assign w_byte_vld = !w_empty && !bus.flush;
    assign w_pop      = w_byte_vld && bus.byte_rdy;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .i_data  (bus.rom_byte),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rom_en   = w_rom_en;
    assign bus.rom_addr = r_fetch_addr;
    assign bus.byte_vld = w_byte_vld;
    assign bus.byte_out = w_head;
    assign bus.byte_pc  = r_fetch_addr - ADDR_W'(w_count);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed-plus-random bench for fetch_queue against a queue-based reference of the prefetch rules.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        data;
    } ent_t;

    logic clock;
    logic reset;
    logic [7:0] rom [65536];

    fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.rom_byte = rom[bus.rom_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;

    ent_t              m_q [$];
    logic [ADDR_W-1:0] m_addr   = '0;
    bit                m_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr   = '0;
        m_active = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_en"},   bus.rom_en,   0);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_byte_vld"}, bus.byte_vld, 0);
        check({tag, "_byte_out"}, bus.byte_out, 0);
        check({tag, "_byte_pc"},  bus.byte_pc,  0);
    endtask

    // One clock: compare against the reference at the falling edge, then advance the reference.
    task automatic cycle();
        bit                exp_en;
        bit                exp_vld;
        logic [ADDR_W-1:0] exp_pc;
        ent_t              e;
        @(negedge clock);
        exp_en  = m_active && (m_q.size() < DEPTH);
        exp_vld = (m_q.size() != 0) && !bus.flush;
        exp_pc  = m_addr - ADDR_W'(m_q.size());
        check("rom_en",   bus.rom_en,   exp_en);
        check("rom_addr", bus.rom_addr, m_addr);
        check("byte_vld", bus.byte_vld, exp_vld);
        check("byte_pc",  bus.byte_pc,  exp_pc);
        if (exp_vld) begin
            check("byte_out",  bus.byte_out, m_q[0].data);
            check("head_pc",   bus.byte_pc,  m_q[0].pc);
        end
        if (bus.rom_en) rd_cnt++;
        if (bus.flush) begin
            m_q.delete();
            m_addr   = bus.flush_addr;
            m_active = 1'b0;
        end else begin
            if (exp_vld && bus.byte_rdy) void'(m_q.pop_front());
            if (exp_en) begin
                e.pc   = m_addr;
                e.data = rom[m_addr];
                m_q.push_back(e);
                m_addr = m_addr + 1'b1;
            end
            m_active = bus.fetch_en;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h0000] = 8'h74;
        rom[16'h0001] = 8'h02;
        rom[16'h000B] = 8'h24;
        rom[16'h000C] = 8'h01;

        reset          = 1'b1;
        bus.fetch_en   = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.byte_rdy   = 1'b0;
        model_reset();
        #1;
        check_zero("reset");

        // Reset release with fetching enabled: 0x74 then 0x02 from cycle 2.
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.fetch_en = 1'b1;
        bus.byte_rdy = 1'b1;
        cycle();
        #1;
        check("t1_rom_en_c1", bus.rom_en, 1);
        cycle();
        #1;
        check("t1_vld_c2", bus.byte_vld, 1);
        check("t1_out0",   bus.byte_out, 8'h74);
        check("t1_pc0",    bus.byte_pc,  16'h0000);
        cycle();
        #1;
        check("t1_out1",   bus.byte_out, 8'h02);
        check("t1_pc1",    bus.byte_pc,  16'h0001);
        repeat (3) cycle();

        // Back-pressure from address 0: exactly DEPTH reads, then stall.
        bus.flush      = 1'b1;
        bus.flush_addr = 16'h0000;
        bus.byte_rdy   = 1'b0;
        cycle();
        bus.flush = 1'b0;
        rd_cnt    = 0;
        repeat (11) cycle();
        check("t2_reads", rd_cnt, DEPTH);
        bus.byte_rdy = 1'b1;
        repeat (8) cycle();

        // Flush to 0x000B while three bytes are queued.
        bus.byte_rdy   = 1'b0;
        bus.flush      = 1'b1;
        bus.flush_addr = 16'h0020;
        cycle();
        bus.flush = 1'b0;
        repeat (4) cycle();
        bus.flush      = 1'b1;
        bus.flush_addr = 16'h000B;
        bus.byte_rdy   = 1'b1;
        #1;
        check("t3_vld_flush", bus.byte_vld, 0);
        cycle();
        bus.flush = 1'b0;
        #1;
        check("t3_vld_redir", bus.byte_vld, 0);
        cycle();
        cycle();
        #1;
        check("t3_out0", bus.byte_out, 8'h24);
        check("t3_pc0",  bus.byte_pc,  16'h000B);
        cycle();
        #1;
        check("t3_out1", bus.byte_out, 8'h01);
        check("t3_pc1",  bus.byte_pc,  16'h000C);

        // Flush together with a pop on a full queue.
        bus.byte_rdy = 1'b0;
        repeat (6) cycle();
        #1;
        check("t4_full_stall", bus.rom_en, 0);
        bus.flush      = 1'b1;
        bus.flush_addr = 16'h0100;
        bus.byte_rdy   = 1'b1;
        cycle();
        bus.flush = 1'b0;
        #1;
        check("t4_vld_redir", bus.byte_vld, 0);
        cycle();
        #1;
        check("t4_vld_first", bus.byte_vld, 0);
        cycle();
        #1;
        check("t4_pc", bus.byte_pc, 16'h0100);
        check("t4_out", bus.byte_out, {24'h0, rom[16'h0100]});
        repeat (3) cycle();

        // Address wrap at the top of the program space.
        bus.flush      = 1'b1;
        bus.flush_addr = 16'hFFFE;
        cycle();
        bus.flush = 1'b0;
        cycle();
        cycle();
        #1;
        check("t5_pc0",  bus.byte_pc,  16'hFFFE);
        check("t5_out0", bus.byte_out, {24'h0, rom[16'hFFFE]});
        cycle();
        #1;
        check("t5_pc1",  bus.byte_pc,  16'hFFFF);
        check("t5_out1", bus.byte_out, {24'h0, rom[16'hFFFF]});
        cycle();
        #1;
        check("t5_pc2",  bus.byte_pc,  16'h0000);
        check("t5_out2", bus.byte_out, 8'h74);

        // Asynchronous reset with two bytes queued.
        bus.byte_rdy   = 1'b0;
        bus.flush      = 1'b1;
        bus.flush_addr = 16'h0300;
        cycle();
        bus.flush = 1'b0;
        repeat (3) cycle();
        #1;
        check("t6_vld_before", bus.byte_vld, 1);
        #1;
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        model_reset();
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.byte_rdy = 1'b1;
        cycle();
        #1;
        check("t6_restart_en",   bus.rom_en,   1);
        check("t6_restart_addr", bus.rom_addr, 0);
        repeat (3) cycle();

        // Randomized traffic: hold, back-pressure and redirects.
        for (int i = 0; i < 400; i++) begin
            bus.fetch_en   = ($urandom_range(0, 9) != 0);
            bus.byte_rdy   = ($urandom_range(0, 2) != 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            bus.flush_addr = 16'($urandom);
            cycle();
        end
        bus.flush = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-byte prefetcher: the initiator side of the program-ROM read port. Issues sequential byte reads to the combinational ROM, buffers returned bytes in a small FIFO, and presents them in order to the decode/control unit via a valid/ready handshake. Supports redirect (jump/call/interrupt vector) by flushing the queue and restarting fetch at a new address.

## Interface
Parameters:
- DEPTH, 4: queue entries, power of two, ≥2.
- ADDR_W, 16: program address width.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_en  in  1  1 = issue reads; 0 = hold (no new reads, queue still drains).
- flush  in  1  one-cycle redirect strobe.
- flush_addr  in  ADDR_W  new fetch address, sampled when flush=1.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_byte  in  8  ROM data, valid combinationally in the same cycle rom_en=1.
- byte_out  out  8  head byte.
- byte_pc  out  ADDR_W  address of head byte.
- byte_vld  out  1  head byte valid.
- byte_rdy  in  1  consumer accepts head byte.

## Operation
- States: IDLE, FETCH, REDIRECT. Reset → IDLE.
- IDLE: rom_en=0. fetch_en=1 → FETCH.
- FETCH: rom_en = (count < DEPTH); rom_addr = fetch_addr. When rom_en=1, rom_byte written to tail at the edge and fetch_addr increments. fetch_en=0 → IDLE (read in that cycle still completes if rom_en=1).
- REDIRECT: one bubble cycle, rom_en=0; then → FETCH if fetch_en=1, else IDLE.
- flush=1 (any state, highest priority): queue cleared, fetch_addr ← flush_addr, state ← REDIRECT; ROM data that cycle discarded; pop ignored.
- Pop: byte_vld & byte_rdy at an edge removes head.
- Push and pop in same cycle: count unchanged; legal when full (no push when full, since rom_en=0).
- byte_vld = (count ≠ 0) & ~flush. byte_out = head entry. byte_pc = fetch_addr − count, modulo 2^ADDR_W.
- fetch_addr wraps 0xFFFF → 0x0000; no error.
- rom_addr drives fetch_addr whenever rom_en=0 as well (no X/Z).

## Timing
- Reset values: rom_en=0, rom_addr=0, byte_vld=0, byte_out=0, byte_pc=0, fetch_addr=0, count=0, state=IDLE.
- Reset asserted mid-operation: all of the above immediately, queue contents lost.
- Fetch latency: read issued in cycle N → byte_vld=1 in cycle N+1.
- From reset release with fetch_en=1: edge 1 IDLE→FETCH, rom_en=1 in cycle 1 (addr 0), byte_vld=1 in cycle 2.
- Flush at edge E: cycle after E is REDIRECT (rom_en=0, byte_vld=0); rom_en=1 with rom_addr=flush_addr one cycle later; that byte is visible at byte_vld two cycles after E+1.
- Steady state with byte_rdy=1: one byte per cycle throughput.
- Back-pressure: byte_rdy=0 → queue fills to DEPTH after DEPTH reads, then rom_en=0 until a pop.

## Structure
- Package fetch_pkg: state enum (IDLE, FETCH, REDIRECT), default DEPTH and ADDR_W constants.
- Sub-module fetch_fifo: DEPTH×8 storage plus per-entry nothing else; head/tail pointers, count, push, pop, clear. PC derived in fetch_queue from fetch_addr and count, not stored.
- fetch_queue holds FSM, fetch_addr, ROM port and handshake logic.

## Test plan
- Reset release, fetch_en=1, ROM[0]=0x74, ROM[1]=0x02, byte_rdy=1 -> byte_vld from cycle 2; bytes 0x74 (pc 0), 0x02 (pc 1) on consecutive cycles.
- byte_rdy=0 for 10 cycles -> exactly DEPTH=4 reads issued (addrs 0–3), rom_en=0 thereafter; release byte_rdy -> bytes of addrs 0,1,2,3,4… in order, no gaps or duplicates.
- Flush with flush_addr=0x000B while queue holds 3 bytes -> byte_vld=0 in flush and REDIRECT cycles; next bytes ROM[0x0B]=0x24 (pc 0x000B), ROM[0x0C]=0x01.
- Flush in same cycle as byte_rdy=1 and full queue -> pop ignored, queue empty, no stale byte emitted afterward.
- flush_addr=0xFFFE -> byte_pc sequence 0xFFFE, 0xFFFF, 0x0000 with matching ROM data.
- Reset asserted mid-stream (count=2) -> outputs zero asynchronously; after release fetch restarts at address 0.
